// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the dual-clock FIFO write and read controllers.
//   Pointer helpers work on a fixed 32-bit word. Callers zero-extend their
//   PTR_WIDTH+1 bit pointers into a ptr_word_t and truncate the result back,
//   so one set of functions serves every FIFO width.
//
//   Contents:
//     PTR_MAX_W        widest supported pointer (PTR_WIDTH+1 <= PTR_MAX_W)
//     ptr_word_t       32-bit pointer carrier type
//     fifo_depth()     2**ptr_width
//     bin2gray()       binary -> reflected Gray
//     gray2bin()       reflected Gray -> binary (prefix XOR from the MSB down)
//     ptr_full_match() Gray "one lap apart" compare, used for full and empty
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    function automatic int unsigned fifo_depth(input int unsigned ptr_width);
        return 32'd1 << ptr_width;
    endfunction

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Two Gray pointers of width pw are exactly one lap (DEPTH entries) apart
    // when their two MSBs are inverted and all lower bits match. The write side
    // uses this for full; the read side calls it with the roles swapped.
    function automatic logic ptr_full_match(input ptr_word_t   wg,
                                            input ptr_word_t   rg,
                                            input int unsigned pw);
        ptr_word_t top2;
        ptr_word_t mask;
        top2 = ptr_word_t'(3) << (pw - 2);
        mask = (ptr_word_t'(1) << pw) - ptr_word_t'(1);
        return ((wg ^ top2) & mask) == (rg & mask);
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// -----------------------------------------------------------------------------
// gray_to_bin
//   Purely combinational Gray-to-binary converter. Each binary bit is the XOR
//   of the Gray bits from its own position up to the MSB. The write controller
//   uses it on the synchronized read pointer; the read controller uses it on
//   the synchronized write pointer.
//
//   Ports:
//     gray  in  WIDTH  Gray-coded value
//     bin   out WIDTH  binary equivalent
// -----------------------------------------------------------------------------
module gray_to_bin #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl
//   Write-side controller of the dual-clock FIFO. Owns the binary and Gray
//   write pointers, drives the memory write strobe and address, and derives
//   full / almost_full / level / sticky overflow against a read pointer that
//   has already been synchronized into this clock domain. wptr_gray is a
//   register output so the read domain can synchronize it glitch-free.
//
//   Parameters:
//     PTR_WIDTH     address bits, depth = 2**PTR_WIDTH (>= 2)
//     AFULL_THRESH  almost_full when level >= this (1..2**PTR_WIDTH)
//
//   Ports:
//     clk             in   1            write-domain clock
//     rst             in   1            synchronous, active-high reset
//     wr_en           in   1            push request
//     ovf_clr         in   1            clears sticky overflow
//     rptr_gray_sync  in   PTR_WIDTH+1  synchronized Gray read pointer
//     mem_we          out  1            combinational memory write enable
//     waddr           out  PTR_WIDTH    registered memory write address
//     wptr_gray       out  PTR_WIDTH+1  registered Gray write pointer
//     full            out  1            registered full flag
//     almost_full     out  1            registered almost-full flag
//     wr_level        out  PTR_WIDTH+1  registered occupancy 0..2**PTR_WIDTH
//     overflow        out  1            registered sticky overflow
// -----------------------------------------------------------------------------
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH    = 5,
    parameter int AFULL_THRESH = 28
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 ovf_clr,
    input  logic [PTR_WIDTH:0]   rptr_gray_sync,
    output logic                 mem_we,
    output logic [PTR_WIDTH-1:0] waddr,
    output logic [PTR_WIDTH:0]   wptr_gray,
    output logic                 full,
    output logic                 almost_full,
    output logic [PTR_WIDTH:0]   wr_level,
    output logic                 overflow
);

    localparam int          PW    = PTR_WIDTH + 1;
    localparam int unsigned DEPTH = fifo_depth(PTR_WIDTH);
    localparam logic [PW-1:0] AF_TH = PW'(AFULL_THRESH);

    if (PTR_WIDTH < 2 || PW > PTR_MAX_W) begin : g_bad_width
        $error("fifo_wr_ctrl: PTR_WIDTH out of range");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > int'(DEPTH)) begin : g_bad_thresh
        $error("fifo_wr_ctrl: AFULL_THRESH out of range");
    end

    logic          push;
    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] level_next;
    logic          full_next;

    gray_to_bin #(
        .WIDTH (PW)
    ) u_rptr_g2b (
        .gray (rptr_gray_sync),
        .bin  (rbin)
    );

    // The memory is never written while reset is held, even though the
    // pointer would be discarded anyway; this keeps stale data out of the RAM.
    assign push   = wr_en & ~full & ~rst;
    assign mem_we = push;

    // Next-state arithmetic is modulo 2**PW by construction of the widths.
    assign wbin_next  = wbin + PW'(push);
    assign gray_next  = PW'(bin2gray(ptr_word_t'(wbin_next)));
    assign level_next = wbin_next - rbin;
    assign full_next  = ptr_full_match(ptr_word_t'(gray_next),
                                       ptr_word_t'(rptr_gray_sync),
                                       PW);

    // ---- register stage: pointers and flags ----
    always_ff @(posedge clk) begin
        if (rst) begin
            wbin        <= '0;
            wptr_gray   <= '0;
            waddr       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wptr_gray   <= gray_next;
            waddr       <= wbin_next[PTR_WIDTH-1:0];
            full        <= full_next;
            almost_full <= (level_next >= AF_TH);
            wr_level    <= level_next;
            // A rejected push in the same cycle as a clear keeps the flag set.
            overflow    <= (overflow & ~ovf_clr) | (wr_en & full);
        end
    end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-side controller for the dual-clock FIFO. It owns the write pointer (binary and Gray), generates the memory write enable and address, and computes full, almost-full, level and overflow. It compares against a read pointer that the two-flop synchronizer has already brought into the write domain. Its registered Gray pointer is the value the read domain synchronizes back.

Parameters:
PTR_WIDTH, 5, address bits; FIFO depth = 2**PTR_WIDTH; pointers are PTR_WIDTH+1 bits; legal range >= 2
AFULL_THRESH, 28, almost_full asserts when level >= this value; legal range 1..2**PTR_WIDTH

Ports:
clk  in  1  write-domain clock
rst  in  1  synchronous, active-high reset
wr_en  in  1  push request
ovf_clr  in  1  clears sticky overflow
rptr_gray_sync  in  PTR_WIDTH+1  read pointer (Gray), already synchronized to clk
mem_we  out  1  combinational: wr_en & ~full
waddr  out  PTR_WIDTH  registered: wbin[PTR_WIDTH-1:0]
wptr_gray  out  PTR_WIDTH+1  registered Gray write pointer
full  out  1  registered
almost_full  out  1  registered
wr_level  out  PTR_WIDTH+1  registered occupancy, 0..2**PTR_WIDTH
overflow  out  1  registered, sticky

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Reset has priority over all inputs.
- Reset values: wbin=0, wptr_gray=0, waddr=0, full=0, almost_full=0, wr_level=0, overflow=0.
- push = wr_en & ~full (identical to mem_we).
- Pointer update:
  - wbin_next = wbin + push, modulo 2**(PTR_WIDTH+1).
  - gray_next = wbin_next ^ (wbin_next >> 1).
  - wbin, wptr_gray and waddr load their next values every cycle.
- Each push moves exactly one wptr_gray bit, including the wrap from all-ones to 0.
- Full:
  - full <= (gray_next == {~rptr_gray_sync[MSB:MSB-1], rptr_gray_sync[MSB-2:0]}).
  - This is the registered, one-cycle update form. Full is conservative because the read pointer is stale by the synchronizer latency.
- Level:
  - rbin = gray-to-binary of rptr_gray_sync.
  - wr_level <= (wbin_next - rbin), modulo 2**(PTR_WIDTH+1).
  - almost_full <= (wbin_next - rbin) >= AFULL_THRESH.
- Overflow:
  - overflow <= (overflow & ~ovf_clr) | (wr_en & full).
  - If ovf_clr and an overflowing wr_en occur in the same cycle, overflow stays 1 (set wins).
- No state machine. The state is the pointer register plus flag registers.
- Latency:
  - An accepted push is visible on wptr_gray, waddr and wr_level at the next clk edge.
  - A change on rptr_gray_sync is reflected in full, almost_full and wr_level at the next edge.
- Boundary conditions:
  - wr_en while full: mem_we=0, pointers hold, overflow sets.
  - Push and read-pointer advance in the same cycle: level unchanged, full unchanged if it was 0.
  - Level exactly 2**PTR_WIDTH: full=1, wr_level=32 at the default width.
  - Reset mid-stream: all state returns to 0 at the next edge regardless of wr_en. The read side must be reset coherently; that is the system's responsibility, not this block's.
- rptr_gray_sync is assumed stable per clk (it is the synchronizer output). No further filtering is applied.

Decomposition:
- Shared package fifo_pkg:
  - DEPTH = 2**PTR_WIDTH
  - bin2gray function
  - gray2bin function (prefix XOR from MSB down)
  - full-compare helper, reused by the read-side empty logic
- One sub-module: gray_to_bin, parameterised on width, purely combinational, instantiated for rptr_gray_sync. The read controller reuses it for the write pointer.

Test Plan (PTR_WIDTH=5, AFULL_THRESH=28):
1. Hold rst=1 with wr_en=1 for 3 cycles -> all outputs 0 and mem_we=0 after the first edge; release -> first push gives wptr_gray=6'b000001, waddr=1.
2. rptr_gray_sync=0, wr_en=1 for 32 cycles:
   - almost_full rises on the edge where wr_level becomes 28.
   - After the 32nd push: full=1, wr_level=32, wptr_gray=6'b110000.
3. Continue wr_en=1 while full -> mem_we=0, wptr_gray stays 6'b110000, overflow=1. overflow persists with wr_en=0; ovf_clr=1 for one cycle -> 0.
4. From full, set rptr_gray_sync=6'b000001 (rbin=1) -> next edge full=0, wr_level=31; almost_full stays 1.
5. Wrap: track the read pointer so the FIFO is never full and push 64 times:
   - waddr goes 31->0 twice.
   - wptr_gray goes 6'b100000 -> 6'b000000 at the 64th push.
   - A checker confirms a single bit changes on every push.
6. At level 31, apply wr_en=1 and advance rptr_gray_sync by one in the same cycle -> wr_level stays 31, full stays 0, mem_we=1.
